// File: rtl/rc4_stream_gen.sv
// RC4 keystream engine: S-box init, KSA, optional drop-n, then PRGA streamed
// over a valid/ready byte interface, either raw keystream or XORed with din.
module rc4_stream_gen #(
  parameter int MAX_KEY_BYTES = 16,
  parameter int DROP_BYTES    = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       mode,
  input  logic [MAX_KEY_BYTES*8-1:0] key,
  input  logic [7:0]                 key_length,
  input  logic [15:0]                ks_count,
  input  logic [7:0]                 din,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic [7:0]                 dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_KSA  = 3'd2;
  localparam logic [2:0] S_DROP = 3'd3;
  localparam logic [2:0] S_PRGA = 3'd4;
  localparam logic [8:0] MAXK   = 9'(MAX_KEY_BYTES);

  logic [7:0]                 sbox [0:255];
  logic [2:0]                 state;
  logic [7:0]                 i, j, kidx, klen_q;
  logic [MAX_KEY_BYTES*8-1:0] key_q;
  logic                       mode_q;
  logic [15:0]                cnt_q, ld_cnt, drop_cnt;

  // KSA datapath; the key byte is picked by a wrapping index instead of a modulo
  logic [7:0] s_i, kb, jn;
  assign s_i = sbox[i];
  assign kb  = 8'(key_q >> {kidx, 3'b000});
  assign jn  = j + s_i + kb;

  // PRGA step; ks is read as if the swap had already happened
  logic [7:0] i1, j1, si, sj, t, ks;
  assign i1 = i + 8'd1;
  assign si = sbox[i1];
  assign j1 = j + si;
  assign sj = sbox[j1];
  assign t  = si + sj;
  assign ks = (t == i1) ? sj : (t == j1) ? si : sbox[t];

  logic key_ok, out_free, last_loaded, fire, accept_last;
  assign key_ok      = (key_length != 8'd0) && ({1'b0, key_length} <= MAXK);
  assign out_free    = !dout_valid || dout_ready;
  assign last_loaded = (cnt_q != 16'd0) && (ld_cnt == cnt_q);
  assign fire        = (state == S_PRGA) && out_free && !last_loaded && !abort &&
                       (!mode_q || din_valid);
  assign accept_last = (state == S_PRGA) && dout_valid && dout_ready && last_loaded;
  assign din_ready   = (state == S_PRGA) && mode_q && out_free && !last_loaded && !abort;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk) begin
    case (state)
      S_INIT: sbox[i] <= i;
      S_KSA: begin
        sbox[i]  <= sbox[jn];
        sbox[jn] <= s_i;
      end
      default: begin
        if (state == S_DROP || fire) begin
          sbox[i1] <= sj;
          sbox[j1] <= si;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      i          <= 8'd0;
      j          <= 8'd0;
      kidx       <= 8'd0;
      klen_q     <= 8'd0;
      key_q      <= '0;
      mode_q     <= 1'b0;
      cnt_q      <= 16'd0;
      ld_cnt     <= 16'd0;
      drop_cnt   <= 16'd0;
      dout       <= 8'd0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      if (state != S_IDLE && abort) begin
        state      <= S_IDLE;
        dout_valid <= 1'b0;
        i          <= 8'd0;
        j          <= 8'd0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (key_ok) begin
                key_q    <= key;
                klen_q   <= key_length;
                mode_q   <= mode;
                cnt_q    <= ks_count;
                done     <= 1'b0;
                i        <= 8'd0;
                j        <= 8'd0;
                kidx     <= 8'd0;
                ld_cnt   <= 16'd0;
                drop_cnt <= 16'd0;
                state    <= S_INIT;
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_INIT: begin
            i <= i + 8'd1;
            if (i == 8'd255) state <= S_KSA;
          end
          S_KSA: begin
            i    <= i + 8'd1;
            j    <= jn;
            kidx <= (kidx == klen_q - 8'd1) ? 8'd0 : kidx + 8'd1;
            if (i == 8'd255) begin
              j     <= 8'd0;
              state <= (DROP_BYTES > 0) ? S_DROP : S_PRGA;
            end
          end
          S_DROP: begin
            i        <= i1;
            j        <= j1;
            drop_cnt <= drop_cnt + 16'd1;
            if (drop_cnt == 16'(DROP_BYTES - 1)) state <= S_PRGA;
          end
          S_PRGA: begin
            if (fire) begin
              i          <= i1;
              j          <= j1;
              dout       <= mode_q ? (din ^ ks) : ks;
              dout_valid <= 1'b1;
              ld_cnt     <= ld_cnt + 16'd1;
            end else if (dout_valid && dout_ready) begin
              dout_valid <= 1'b0;
            end
            if (accept_last) begin
              state      <= S_IDLE;
              dout_valid <= 1'b0;
              done       <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rc4_stream_gen.sv
// Directed bench for rc4_stream_gen: known RC4 vectors, backpressure, din gaps,
// drop-n, err/abort/reset corner cases.
module tb_rc4_stream_gen;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, abort = 1'b0, mode = 1'b0, sel = 1'b0;
  logic [127:0] key = '0;
  logic [7:0]   key_length = 8'd0;
  logic [15:0]  ks_count = 16'd0;
  logic [7:0]   din = 8'd0;
  logic         din_valid = 1'b0, dout_ready = 1'b1;
  logic         start0, start1;
  logic [7:0]   dout0, dout1, dout;
  logic         din_ready0, din_ready1, din_ready;
  logic         dout_valid0, dout_valid1, dout_valid;
  logic         busy0, busy1, busy, done0, done1, done, err0, err1, err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign start0     = start & ~sel;
  assign start1     = start & sel;
  assign dout       = sel ? dout1 : dout0;
  assign dout_valid = sel ? dout_valid1 : dout_valid0;
  assign din_ready  = sel ? din_ready1 : din_ready0;
  assign busy       = sel ? busy1 : busy0;
  assign done       = sel ? done1 : done0;
  assign err        = sel ? err1 : err0;

  rc4_stream_gen #(.MAX_KEY_BYTES(16), .DROP_BYTES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .mode(mode),
    .key(key), .key_length(key_length), .ks_count(ks_count), .din(din),
    .din_valid(din_valid), .din_ready(din_ready0), .dout(dout0),
    .dout_valid(dout_valid0), .dout_ready(dout_ready), .busy(busy0),
    .done(done0), .err(err0));

  rc4_stream_gen #(.MAX_KEY_BYTES(16), .DROP_BYTES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .mode(mode),
    .key(key), .key_length(key_length), .ks_count(ks_count), .din(din),
    .din_valid(din_valid), .din_ready(din_ready1), .dout(dout1),
    .dout_valid(dout_valid1), .dout_ready(dout_ready), .busy(busy1),
    .done(done1), .err(err1));

  typedef struct {
    logic [127:0] key;
    logic [7:0]   kl;
    logic         mode;
    logic [15:0]  cnt;
    logic [79:0]  din;
    logic [79:0]  exp;
    logic         bp;
    logic         gap;
    int           lat;
    logic         sel;
  } vec_t;

  vec_t vecs [6];

  localparam logic [127:0] K_KEY    = 128'h79654B;
  localparam logic [127:0] K_WIKI   = 128'h696B6957;
  localparam logic [127:0] K_SECRET = 128'h746572636553;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic start_only(input logic [127:0] k, input logic [7:0] kl,
                            input logic m, input logic [15:0] c);
    sel = 1'b0;
    @(posedge clk); #1;
    key = k; key_length = kl; mode = m; ks_count = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input int v);
    vec_t vv;
    int   e, nout, nin, lat_seen;
    logic prev_hold;
    logic [7:0] prev_dout;
    vv = vecs[v];
    sel = vv.sel;
    @(posedge clk); #1;
    key = vv.key; key_length = vv.kl; mode = vv.mode; ks_count = vv.cnt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = 0; nout = 0; nin = 0; lat_seen = 0; prev_hold = 1'b0; prev_dout = 8'd0;
    while (nout < int'(vv.cnt) && e < 3000) begin
      dout_ready = vv.bp ? ((e % 4 == 0) || (e % 4 == 3)) : 1'b1;
      din_valid  = vv.mode && (vv.gap ? (e % 3 != 1) : 1'b1);
      din        = (nin < 10) ? vv.din[nin*8 +: 8] : 8'd0;
      @(negedge clk);
      if (e == 0) begin
        chk($sformatf("vec%0d done_cleared", v), 32'(done), 32'd0);
        chk($sformatf("vec%0d busy_run", v), 32'(busy), 32'd1);
      end
      if (dout_valid && lat_seen == 0) lat_seen = e;
      if (prev_hold) begin
        chk($sformatf("vec%0d hold_data", v), 32'(dout), 32'(prev_dout));
        chk($sformatf("vec%0d hold_valid", v), 32'(dout_valid), 32'd1);
      end
      if (dout_valid && dout_ready) begin
        chk($sformatf("vec%0d byte%0d", v, nout), 32'(dout), 32'(vv.exp[nout*8 +: 8]));
        nout++;
      end
      if (din_valid && din_ready) nin++;
      prev_hold = dout_valid && !dout_ready;
      prev_dout = dout;
      @(posedge clk); #1;
      e++;
    end
    if (nout < int'(vv.cnt)) chk($sformatf("vec%0d timeout_bytes", v), 32'(nout), 32'(vv.cnt));
    if (vv.lat != 0) chk($sformatf("vec%0d latency", v), 32'(lat_seen), 32'(vv.lat));
    chk($sformatf("vec%0d end_busy", v), 32'(busy), 32'd0);
    chk($sformatf("vec%0d end_done", v), 32'(done), 32'd1);
    chk($sformatf("vec%0d end_valid", v), 32'(dout_valid), 32'd0);
    dout_ready = 1'b1;
    din_valid  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{K_KEY, 8'd3, 1'b0, 16'd10, 80'h0,
                80'h19_A7_72_CA_34_B7_81_77_9F_EB, 1'b0, 1'b0, 513, 1'b0};
    vecs[1] = '{K_WIKI, 8'd4, 1'b1, 16'd5, 80'h61_69_64_65_70,
                80'h20_04_BF_21_10, 1'b0, 1'b0, 513, 1'b0};
    vecs[2] = '{K_SECRET, 8'd6, 1'b0, 16'd4, 80'h0,
                80'h05_6B_D4_04, 1'b0, 1'b0, 513, 1'b0};
    vecs[3] = '{K_KEY, 8'd3, 1'b0, 16'd10, 80'h0,
                80'h19_A7_72_CA_34_B7_81_77_9F_EB, 1'b1, 1'b0, 0, 1'b0};
    vecs[4] = '{K_WIKI, 8'd4, 1'b1, 16'd5, 80'h61_69_64_65_70,
                80'h20_04_BF_21_10, 1'b1, 1'b1, 0, 1'b0};
    vecs[5] = '{K_KEY, 8'd3, 1'b0, 16'd3, 80'h0,
                80'h0_B7_81_77, 1'b0, 1'b0, 515, 1'b1};

    #12;
    chk("rst_dout", 32'(dout0), 32'd0);
    chk("rst_valid", 32'(dout_valid0), 32'd0);
    chk("rst_din_ready", 32'(din_ready0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) run_vec(v);

    // rejected key lengths
    start_only(K_KEY, 8'd0, 1'b0, 16'd4);
    chk("err_len0", 32'(err), 32'd1);
    chk("err_len0_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("err_len0_pulse", 32'(err), 32'd0);
    start_only(K_KEY, 8'd17, 1'b0, 16'd4);
    chk("err_len17", 32'(err), 32'd1);
    chk("err_len17_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("err_len17_pulse", 32'(err), 32'd0);

    // abort during KSA
    start_only(K_KEY, 8'd3, 1'b0, 16'd10);
    repeat (300) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_ksa_busy", 32'(busy), 32'd0);
    chk("abort_ksa_valid", 32'(dout_valid), 32'd0);
    chk("abort_ksa_done", 32'(done), 32'd0);

    // abort mid-PRGA with an unbounded stream
    dout_ready = 1'b1;
    start_only(K_KEY, 8'd3, 1'b0, 16'd0);
    repeat (520) @(posedge clk);
    #1;
    chk("abort_prga_pre_valid", 32'(dout_valid), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_prga_busy", 32'(busy), 32'd0);
    chk("abort_prga_valid", 32'(dout_valid), 32'd0);
    chk("abort_prga_done", 32'(done), 32'd0);

    // abort alone in IDLE does nothing; together with start, start wins
    abort = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle_busy", 32'(busy), 32'd0);
    key = K_KEY; key_length = 8'd3; mode = 1'b0; ks_count = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_start_cleanup", 32'(busy), 32'd0);

    // async reset mid-PRGA, then a fresh run reproduces the stream
    start_only(K_KEY, 8'd3, 1'b0, 16'd0);
    repeat (515) @(posedge clk);
    #1;
    chk("rstmid_pre_valid", 32'(dout_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_dout", 32'(dout), 32'd0);
    chk("rstmid_valid", 32'(dout_valid), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rc4_stream_gen.md
Name: rc4_stream_gen

Overview:
- Parametrised RC4 keystream engine, successor to the fixed 4-byte RC4 core.
- Runs a full S-box init, KSA and PRGA, and streams keystream bytes through a valid/ready handshake.
- Generalises to configurable max key size, programmable stream length, optional RC4-drop[n], and an in-line XOR cipher mode.
- Sits between key/config registers and the downstream byte-stream datapath.

Parameters:
- MAX_KEY_BYTES, 16: maximum key bytes accepted; key bus width is MAX_KEY_BYTES*8.
- DROP_BYTES, 0: keystream bytes generated and discarded before the first output (RC4-drop[n]).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin; honoured only in IDLE.
- abort  in  1  cancel the current run; return to IDLE.
- mode  in  1  0 = raw keystream out; 1 = dout is din XOR keystream. Sampled at start.
- key  in  MAX_KEY_BYTES*8  key; byte n is key[n*8+:8]. Sampled at start.
- key_length  in  8  number of key bytes, 1..MAX_KEY_BYTES. Sampled at start.
- ks_count  in  16  output bytes to deliver; 0 = unbounded until abort. Sampled at start.
- din  in  8  plaintext/ciphertext byte (mode 1 only).
- din_valid  in  1  din qualifier.
- din_ready  out  1  din accepted when din_valid && din_ready.
- dout  out  8  keystream or XOR result.
- dout_valid  out  1  dout qualifier.
- dout_ready  in  1  downstream accept.
- busy  out  1  high in every state except IDLE.
- done  out  1  sticky; set when ks_count bytes have been accepted; cleared by the next accepted start.
- err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset (async assert, sync-to-clk deassert use):
  - dout = 0x00; dout_valid, din_ready, busy, done, err = 0.
  - State = IDLE; i = j = 0; out-count = 0.
- Internal storage:
  - S-box is a 256x8 register array with combinational reads and up to two writes per cycle (swap).
  - All index arithmetic is mod 256 (8-bit wrap).
- Start handling:
  - In IDLE, start with key_length in 1..MAX_KEY_BYTES latches key, key_length, mode and ks_count, clears done, and enters INIT.
  - Otherwise start pulses err for one cycle and the block stays IDLE.
  - start outside IDLE is ignored.
- INIT: 256 cycles, writing S[c] = c for c = 0..255. Then i = j = 0 and go to KSA.
- KSA: 256 cycles, one i per cycle:
  - jn = j + S[i] + key[i mod key_length].
  - Swap S[i] and S[jn]; j <= jn; i++.
  - After i = 255, set i = j = 0. Go to DROP if DROP_BYTES > 0, else PRGA.
- PRGA step (one cycle, used by DROP and PRGA):
  - i1 = i+1; j1 = j + S[i1]; swap S[i1] and S[j1]; t = S[i1] + S[j1] (pre-swap values).
  - ks = post-swap S[t]: if t == i1 use old S[j1]; else if t == j1 use old S[i1]; else S[t].
  - If i1 == j1, the swap is a no-op.
- DROP: DROP_BYTES consecutive steps with no output, then PRGA.
- PRGA: a step fires only when the output register is empty or being emptied (dout_valid == 0 or dout_ready == 1).
  - mode 1 additionally requires din_valid; din_ready = (state == PRGA) && mode && (output register free).
  - mode 0: din_ready = 0.
  - A fired step loads dout = ks (mode 0) or din ^ ks (mode 1) and sets dout_valid the next edge.
  - dout is held stable while dout_valid && !dout_ready.
  - Sustained throughput is 1 byte/cycle.
- Latency: with dout_ready = 1 (and din_valid = 1 in mode 1), dout_valid first rises 513 + DROP_BYTES edges after the start edge.
- Completion (ks_count != 0):
  - On the handshake of the ks_count-th byte: go to IDLE, dout_valid = 0, done = 1.
  - No further step fires after the last byte is loaded.
- ks_count = 0: PRGA runs until abort; the internal i/j/count wrap freely.
- abort: in any non-IDLE state, go to IDLE next edge.
  - dout_valid and din_ready drop; an unaccepted pending byte is discarded; done stays 0.
  - abort in IDLE: no effect.
  - abort and start in the same cycle in IDLE: start wins.
- Asserting rst_n low mid-run clears everything immediately; no partial output remains.

Test Plan:
- Key "Key" (key[23:0] = 0x79654B, key_length = 3), mode 0, ks_count = 10, dout_ready = 1 -> dout = EB 9F 77 81 B7 34 CA 72 A7 19; first dout_valid at edge 513; done = 1 after the 10th byte; busy = 0.
- Key "Wiki", mode 1, din = "pedia" -> dout = 10 21 BF 04 20. Then key "Secret", mode 0, ks_count = 4 -> 04 D4 6B 05. Back-to-back starts; done clears on the second start.
- DROP_BYTES = 2, key "Key", ks_count = 3 -> dout = 77 81 B7; first dout_valid at edge 515.
- Backpressure: dout_ready toggling 1,0,0,1,... with key "Key" -> dout holds stable while stalled; byte sequence identical to scenario 1, with no drops or duplicates. mode 1 with din_valid gaps -> output pauses with no skipped keystream.
- start with key_length = 0, and separately key_length = MAX_KEY_BYTES + 1 -> err = 1 for one cycle; busy = 0. abort during KSA and mid-PRGA -> IDLE next edge; dout_valid = 0; done = 0.
- Assert rst_n low mid-PRGA while dout_valid = 1 -> all outputs 0 immediately; a fresh start with key "Key" reproduces EB 9F 77 from the start.
